// File: rtl/nexi_uart_rx_fifo.sv
// nexi_uart_rx_fifo: 16x-oversampled UART receiver feeding a first-word-fall-through FIFO.
// Frame: 1 start bit, DATA_BITS data bits (LSB first), optional parity, 1 or 2 stop bits.
// Framing, parity and overrun errors are sticky until err_clr.
// Optional build macro NEXI_UART_RX_BREAK_EN adds a sticky break_det output: an all-zero
// frame (data, parity and stop bits) then reports a break instead of a framing error.
module nexi_uart_rx_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk_16x_bps,
    input  logic                 rst_n,
    input  logic                 rx_pin,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic [CNT_W-1:0]     fifo_count,
    input  logic                 err_clr,
    output logic                 framing_err,
    output logic                 parity_err,
`ifdef NEXI_UART_RX_BREAK_EN
    output logic                 overrun,
    output logic                 break_det
`else
    output logic                 overrun
`endif
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic        PAR_ODD = (PARITY == 1);
`ifdef NEXI_UART_RX_BREAK_EN
    localparam logic        BREAK_EN = 1'b1;
`else
    localparam logic        BREAK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    // ------------------------------------------------------------------
    // Input synchroniser and edge detect
    // ------------------------------------------------------------------
    logic sync1_q, sync2_q, sync3_q;
    logic fall;

    // Two flops against metastability, third flop for falling-edge detection.
    always_ff @(posedge clk_16x_bps) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
        end else begin
            sync1_q <= rx_pin;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign fall = sync3_q & ~sync2_q;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [2:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic                 par_bad_q, par_bad_d;
    logic                 stop_low_q, stop_low_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 all_zero_q, all_zero_d;
    logic                 armed_q, armed_d;
    logic                 maj;
    logic                 push_req;
    logic                 set_frame;
    logic                 set_parity;
`ifdef NEXI_UART_RX_BREAK_EN
    logic                 set_break;
`endif

    assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

    // FSM state and per-frame bookkeeping registers.
    always_ff @(posedge clk_16x_bps) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            samp_q     <= '0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            par_bad_q  <= 1'b0;
            stop_low_q <= 1'b0;
            stop_idx_q <= 1'b0;
            all_zero_q <= 1'b0;
            armed_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            par_bad_q  <= par_bad_d;
            stop_low_q <= stop_low_d;
            stop_idx_q <= stop_idx_d;
            all_zero_q <= all_zero_d;
            armed_q    <= armed_d;
        end
    end

    // Next-state logic: mid-bit sampling, bit assembly and end-of-frame decisions.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        par_bad_d  = par_bad_q;
        stop_low_d = stop_low_q;
        stop_idx_d = stop_idx_q;
        all_zero_d = all_zero_q;
        armed_d    = armed_q;
        push_req   = 1'b0;
        set_frame  = 1'b0;
        set_parity = 1'b0;
`ifdef NEXI_UART_RX_BREAK_EN
        set_break  = 1'b0;
`endif

        // After a break the line must be seen high before a new start is accepted.
        if (!armed_q && sync2_q) begin
            armed_d = 1'b1;
        end

        if (state_q != StIdle) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) samp_d[0] = sync2_q;
            if (cnt_q == 4'd8) samp_d[1] = sync2_q;
            if (cnt_q == 4'd9) samp_d[2] = sync2_q;
        end

        unique case (state_q)
            StIdle: begin
                if (fall && armed_q) begin
                    state_d    = StStart;
                    cnt_d      = '0;
                    bit_idx_d  = '0;
                    par_bad_d  = 1'b0;
                    stop_low_d = 1'b0;
                    stop_idx_d = 1'b0;
                    all_zero_d = 1'b1;
                end
            end
            StStart: begin
                if (cnt_q == 4'd10 && maj) begin
                    state_d = StIdle;  // false start, glitch on idle line
                end else if (cnt_q == 4'd15) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (cnt_q == 4'd15) begin
                    shift_d    = {maj, shift_q[DATA_BITS-1:1]};
                    all_zero_d = all_zero_q & ~maj;
                    bit_idx_d  = bit_idx_q + 4'd1;
                    if (bit_idx_q == 4'(DATA_BITS - 1)) begin
                        state_d = (PARITY != 0) ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (cnt_q == 4'd15) begin
                    par_bad_d  = (^shift_q) ^ maj ^ PAR_ODD;
                    all_zero_d = all_zero_q & ~maj;
                    state_d    = StStop;
                end
            end
            StStop: begin
                if (STOP_BITS == 2 && !stop_idx_q) begin
                    if (cnt_q == 4'd15) begin
                        stop_low_d = ~maj;
                        all_zero_d = all_zero_q & ~maj;
                        stop_idx_d = 1'b1;
                    end
                end else if (cnt_q == 4'd10) begin
                    // Leave early so a start edge in the stop bit's second half is caught.
                    state_d = StIdle;
                    if (stop_low_q || !maj) begin
                        if (BREAK_EN && all_zero_q && !maj) begin
`ifdef NEXI_UART_RX_BREAK_EN
                            set_break = 1'b1;
`endif
                            armed_d   = 1'b0;
                        end else begin
                            set_frame = 1'b1;
                        end
                    end else begin
                        push_req   = 1'b1;
                        set_parity = par_bad_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Receive FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 full;
    logic                 pop;
    logic                 push_ok;
    logic                 ovr_set;

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop     = rd_en && (count_q != '0);
    // A pop on the same edge frees the slot, so a full FIFO still accepts the frame.
    assign push_ok = push_req && (!full || pop);
    assign ovr_set = push_req && full && !pop;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_16x_bps) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // Pointers wrap naturally since FIFO_DEPTH is a power of two.
    always_ff @(posedge clk_16x_bps) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push_ok) count_q <= count_q - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags: a set on the same edge as err_clr wins.
    // ------------------------------------------------------------------
    logic framing_q, parity_q, overrun_q;

    // Flag registers.
    always_ff @(posedge clk_16x_bps) begin
        if (!rst_n) begin
            framing_q <= 1'b0;
            parity_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            framing_q <= set_frame  | (framing_q & ~err_clr);
            parity_q  <= set_parity | (parity_q  & ~err_clr);
            overrun_q <= ovr_set    | (overrun_q & ~err_clr);
        end
    end

`ifdef NEXI_UART_RX_BREAK_EN
    logic break_q;

    // Break flag register.
    always_ff @(posedge clk_16x_bps) begin
        if (!rst_n) begin
            break_q <= 1'b0;
        end else begin
            break_q <= set_break | (break_q & ~err_clr);
        end
    end

    assign break_det = break_q;
`endif

    assign data_valid  = (count_q != '0);
    assign data        = data_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_count  = count_q;
    assign framing_err = framing_q;
    assign parity_err  = parity_q;
    assign overrun     = overrun_q;

endmodule
